sweep_sequencer: RTL

Parametrised generation sequencer for the ant simulation; it is the successor to the fixed simulation-state controller, clock divider and location-scanner trio. It owns the game tick, the raster sweep of the environment grid, and the view/write location pair feeding the environment memory and environment cache. It adds programmable grid size, a configurable view-ahead distance, run/pause/step/free-run modes, downstream back-pressure, a generation counter and overrun detection.

---
 rtl/sweep_sequencer_pkg.sv | 22 ++
 rtl/sweep_sequencer_raster_counter.sv | 58 +++++
 rtl/sweep_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sweep_sequencer_pkg.sv
// Shared types and grid defaults for the generation sequencer.
package sweep_sequencer_pkg;

   localparam int X_BITS_DEF = 8;
   localparam int Y_BITS_DEF = 7;
   localparam int X_DIM_DEF  = 160;
   localparam int Y_DIM_DEF  = 120;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_PAUSE   = 2'd1,
      MODE_STEP    = 2'd2,
      MODE_FREERUN = 2'd3
   } sweep_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_e;

endpackage

// File: rtl/sweep_sequencer_raster_counter.sv
// Raster-order (x,y) location counter; wraps or saturates at the last cell.
module raster_counter #(
   parameter int X_BITS   = 8,
   parameter int Y_BITS   = 7,
   parameter int X_DIM    = 160,
   parameter int Y_DIM    = 120,
   parameter bit SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic              wrap
);

   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_DIM - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_DIM - 1);

   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;

   // wrap is a level: the counter currently addresses the final cell
   assign wrap = (x_q == X_LAST) && (y_q == Y_LAST);
   assign x    = x_q;
   assign y    = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (en) begin
         if (x_q != X_LAST) begin
            x_d = x_q + X_BITS'(1);
         end else if (y_q != Y_LAST) begin
            x_d = '0;
            y_d = y_q + Y_BITS'(1);
         end else if (!SATURATE) begin
            x_d = '0;
            y_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/sweep_sequencer.sv
// Generation sequencer: game tick, raster sweep of the environment grid and
// the view/write location pair, with run/pause/step/free-run control.
module sweep_sequencer
   import sweep_sequencer_pkg::*;
#(
   parameter int X_BITS      = X_BITS_DEF,
   parameter int Y_BITS      = Y_BITS_DEF,
   parameter int X_DIM       = X_DIM_DEF,
   parameter int Y_DIM       = Y_DIM_DEF,
   parameter int LEAD        = 2,
   parameter int FACTOR_BITS = 26,
   parameter int GEN_BITS    = 16
) (
   input  logic                   clk,
   input  logic                   RESET_N,
   input  logic                   SETUP_MODE,
   input  logic [1:0]             mode,
   input  logic                   step_req,
   input  logic [FACTOR_BITS-1:0] factor,
   input  logic                   env_ready,
   output logic [X_BITS-1:0]      view_x,
   output logic [Y_BITS-1:0]      view_y,
   output logic [X_BITS-1:0]      write_x,
   output logic [Y_BITS-1:0]      write_y,
   output logic                   write_flag,
   output logic                   game_tick,
   output logic                   sweep_busy,
   output logic [GEN_BITS-1:0]    gen_count,
   output logic                   overrun
);

   localparam int CELLS  = X_DIM * Y_DIM;
   localparam int A_BITS = $clog2(CELLS + LEAD + 1);

   sweep_state_e           state_q, state_d;
   logic [A_BITS-1:0]      a_q, a_d;
   logic [FACTOR_BITS-1:0] timer_q, timer_d;
   logic [GEN_BITS-1:0]    gen_q, gen_d;
   logic                   ovr_q, ovr_d;
   logic                   tick_q, tick_d;

   sweep_mode_e            mode_e;
   logic [FACTOR_BITS-1:0] tick_lim;
   logic                   sweeping, is_idle, write_on, timer_evt, launch;
   logic                   view_en, ptr_clr, view_last, write_last;

   assign mode_e   = sweep_mode_e'(mode);
   assign sweeping = (state_q == ST_SWEEP);
   assign is_idle  = (state_q == ST_IDLE);
   assign tick_lim = (factor == '0) ? '0 : factor - FACTOR_BITS'(1);

   // Writes begin once the view pointer is LEAD cells ahead
   if (LEAD == 0) begin : g_no_lead
      assign write_on = 1'b1;
   end else begin : g_lead
      assign write_on = (a_q >= A_BITS'(LEAD));
   end

   assign write_flag = sweeping & write_on & env_ready & ~SETUP_MODE;
   assign view_en    = sweeping & env_ready & ~SETUP_MODE & ~view_last;
   assign ptr_clr    = SETUP_MODE | (state_q == ST_DONE);

   raster_counter #(
      .X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_DIM(X_DIM), .Y_DIM(Y_DIM), .SATURATE(1'b1)
   ) u_view (
      .clk(clk), .rst_n(RESET_N), .en(view_en), .clr(ptr_clr),
      .x(view_x), .y(view_y), .wrap(view_last)
   );

   raster_counter #(
      .X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_DIM(X_DIM), .Y_DIM(Y_DIM), .SATURATE(1'b0)
   ) u_write (
      .clk(clk), .rst_n(RESET_N), .en(write_flag), .clr(ptr_clr),
      .x(write_x), .y(write_y), .wrap(write_last)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      timer_d   = timer_q;
      gen_d     = gen_q;
      ovr_d     = ovr_q;
      tick_d    = 1'b0;
      timer_evt = 1'b0;
      launch    = 1'b0;

      // >= rather than == so a lowered factor cannot strand the timer
      unique case (mode_e)
         MODE_RUN: begin
            if (timer_q >= tick_lim) begin
               timer_d   = '0;
               timer_evt = 1'b1;
            end else begin
               timer_d = timer_q + FACTOR_BITS'(1);
            end
         end
         MODE_PAUSE: timer_d = timer_q;
         default:    timer_d = '0;
      endcase

      unique case (mode_e)
         MODE_RUN:     launch = timer_evt;
         MODE_STEP:    launch = step_req & is_idle;
         MODE_FREERUN: launch = is_idle;
         default:      launch = 1'b0;
      endcase

      if ((mode_e == MODE_RUN) && timer_evt && !is_idle) ovr_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_SWEEP;
               a_d     = '0;
               tick_d  = 1'b1;
            end
         end
         ST_SWEEP: begin
            if (env_ready) begin
               if (write_flag && write_last) begin
                  state_d = ST_DONE;
                  a_d     = '0;
               end else begin
                  a_d = a_q + A_BITS'(1);
               end
            end
         end
         ST_DONE: begin
            gen_d   = gen_q + GEN_BITS'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (SETUP_MODE) begin
         state_d = ST_IDLE;
         a_d     = '0;
         timer_d = '0;
         gen_d   = '0;
         ovr_d   = 1'b0;
         tick_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         timer_q <= '0;
         gen_q   <= '0;
         ovr_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         timer_q <= timer_d;
         gen_q   <= gen_d;
         ovr_q   <= ovr_d;
         tick_q  <= tick_d;
      end
   end

   assign game_tick  = tick_q;
   assign sweep_busy = sweeping;
   assign gen_count  = gen_q;
   assign overrun    = ovr_q;

endmodule
